// File: rtl/array_mult_reg.sv
// Unsigned WIDTH x WIDTH array multiplier: AND partial products, carry-save adder rows,
// final ripple row, one output register.
module array_mult_reg #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     inp1,
    input  logic [WIDTH-1:0]     inp2,
    output logic [2*WIDTH-1:0]   product
);

    logic [2*WIDTH-1:0] product_d;
    logic [2*WIDTH-1:0] product_q;

    // Returns {carry, sum}
    function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
        logic s;
        logic co;
        s  = a ^ b ^ c;
        co = (a & b) | (c & (a ^ b));
        return {co, s};
    endfunction

    function automatic logic [1:0] ha(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

    always_comb begin
        logic [WIDTH-1:0] pp [WIDTH];
        logic [WIDTH-1:0] sum_r;
        logic [WIDTH-1:0] carry_r;
        logic [WIDTH-1:0] sum_n;
        logic [WIDTH-1:0] carry_n;
        logic [WIDTH:0]   sum_x;
        logic [1:0]       r;
        logic             rc;

        product_d = '0;
        sum_n     = '0;
        carry_n   = '0;
        r         = '0;
        rc        = 1'b0;

        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp[i][j] = inp1[j] & inp2[i];
            end
        end

        sum_r        = pp[0];
        carry_r      = '0;
        product_d[0] = sum_r[0];

        // Each row folds pp[i] into the previous row's sums (shifted down one) and carries;
        // the top sum input has nothing above it and is tied low.
        for (int i = 1; i < WIDTH; i++) begin
            sum_x = {1'b0, sum_r};
            for (int j = 0; j < WIDTH; j++) begin
                if (i == 1) begin
                    r = ha(pp[i][j], sum_x[j+1]);
                end else begin
                    r = fa(pp[i][j], sum_x[j+1], carry_r[j]);
                end
                sum_n[j]   = r[0];
                carry_n[j] = r[1];
            end
            sum_r        = sum_n;
            carry_r      = carry_n;
            product_d[i] = sum_r[0];
        end

        // Resolve the last row's sums and carries into the upper half of the product
        sum_x = {1'b0, sum_r};
        for (int j = 0; j < WIDTH; j++) begin
            if (j == 0) begin
                r = ha(sum_x[j+1], carry_r[j]);
            end else begin
                r = fa(sum_x[j+1], carry_r[j], rc);
            end
            product_d[WIDTH+j] = r[0];
            rc                 = r[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            product_q <= '0;
        end else begin
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_array_mult_reg.sv
// Self-checking bench for array_mult_reg at WIDTH=4 (directed, exhaustive) and WIDTH=8 (random).
module tb_array_mult_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a4  = '0;
    logic [3:0] b4  = '0;
    logic [7:0] p4;
    logic [7:0] a8  = '0;
    logic [7:0] b8  = '0;
    logic [15:0] p8;

    int n_tests = 0;
    int n_fail  = 0;

    array_mult_reg #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .inp1    (a4),
        .inp2    (b4),
        .product (p4)
    );

    array_mult_reg #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .inp1    (a8),
        .inp2    (b8),
        .product (p8)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] acc;
        acc = '0;
        for (int k = 0; k < 8; k++) begin
            if (y[k]) acc = acc + (16'(x) << k);
        end
        return acc;
    endfunction

    initial begin
        vec_t vecs [10];
        logic [7:0] ea;
        logic [7:0] eb;

        vecs[0] = '{8'd3,  8'd4,  8'd12};
        vecs[1] = '{8'd13, 8'd0,  8'd0};
        vecs[2] = '{8'd10, 8'd12, 8'd120};
        vecs[3] = '{8'd11, 8'd6,  8'd66};
        vecs[4] = '{8'd1,  8'd15, 8'd15};
        vecs[5] = '{8'd20, 8'd3,  8'd12};
        vecs[6] = '{8'd16, 8'd13, 8'd0};
        vecs[7] = '{8'd28, 8'd10, 8'd120};
        vecs[8] = '{8'd22, 8'd11, 8'd66};
        vecs[9] = '{8'd17, 8'd15, 8'd15};

        // Reset held with max operands
        rst = 1'b1; a4 = 4'd15; b4 = 4'd15; a8 = 8'd255; b8 = 8'd255;
        step();
        chk("reset_edge1", 16'(p4), 16'd0);
        step();
        chk("reset_edge2", 16'(p4), 16'd0);
        chk("reset_w8", p8, 16'd0);
        rst = 1'b0;
        step();
        chk("release_max", 16'(p4), 16'd225);
        chk("w8_max", p8, 16'd65025);

        // Directed and truncation table
        for (int i = 0; i < 10; i++) begin
            a4 = vecs[i].a[3:0];
            b4 = vecs[i].b[3:0];
            step();
            chk($sformatf("vec%0d", i), 16'(p4), 16'(vecs[i].exp));
        end

        // Back-to-back stream, new pair every edge
        for (int k = 0; k < 16; k++) begin
            a4 = 4'(k);
            b4 = 4'((k * 7 + 3) % 16);
            step();
            chk($sformatf("stream%0d", k), 16'(p4), ref_mul(8'(a4), 8'(b4)));
        end

        // Inputs change between edges: output holds until next edge
        a4 = 4'd3; b4 = 4'd5;
        step();
        chk("hold_a", 16'(p4), 16'd15);
        a4 = 4'd15; b4 = 4'd15;
        #3;
        chk("hold_b", 16'(p4), 16'd15);
        step();
        chk("hold_c", 16'(p4), 16'd225);

        // Mid-stream reset
        a4 = 4'd5; b4 = 4'd7;
        step();
        chk("mid_pre", 16'(p4), 16'd35);
        a4 = 4'd9; b4 = 4'd9; rst = 1'b1;
        step();
        chk("mid_rst", 16'(p4), 16'd0);
        rst = 1'b0; a4 = 4'd6; b4 = 4'd7;
        step();
        chk("mid_post", 16'(p4), 16'd42);

        // Exhaustive WIDTH=4
        for (int i = 0; i < 256; i++) begin
            a4 = 4'(i / 16);
            b4 = 4'(i % 16);
            step();
            chk($sformatf("exh_%0dx%0d", a4, b4), 16'(p4), ref_mul(8'(a4), 8'(b4)));
        end

        // Random WIDTH=8
        for (int i = 0; i < 10000; i++) begin
            ea = 8'($urandom_range(0, 255));
            eb = 8'($urandom_range(0, 255));
            a8 = ea; b8 = eb;
            step();
            chk($sformatf("rnd_%0dx%0d", ea, eb), p8, ref_mul(ea, eb));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
